pipe_rf: RTL and testbench
==========================

PIPE_RF -- requirements
Module: pipe_rf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; depth 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 3, read port count (1..4).
REQ-004 SHALL have parameter NUM_WR, default 2, write port count (1..2).
REQ-005 SHALL have port rf_clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rf_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rd_addr  input  NUM_RD*ADDR_W  packed read indices, port i at [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_data  output  NUM_RD*DATA_W  packed combinational read data.
REQ-009 SHALL have port rd_busy  output  NUM_RD  scoreboard busy bit of each read index.
REQ-010 SHALL have port wr_en  input  NUM_WR  write enables.
REQ-011 SHALL have port wr_addr  input  NUM_WR*ADDR_W  write indices.
REQ-012 SHALL have port wr_be  input  NUM_WR*DATA_W/8  byte enables per write port.
REQ-013 SHALL have port wr_data  input  NUM_WR*DATA_W  write data.
REQ-014 SHALL have port iss_en  input  1  mark iss_addr pending (producer issued).
REQ-015 SHALL have port iss_addr  input  ADDR_W  index to mark busy.
REQ-016 SHALL have port init_done  output  1  high once array clear finished.

Function
REQ-017 SHALL implement FSM states INIT and READY; INIT entered on reset, clears one entry per cycle from index 0 upward via a counter, moves to READY after entry 2**ADDR_W-1 is cleared (2**ADDR_W cycles).
REQ-018 SHALL hold init_done=0 in INIT, 1 in READY; in INIT ignore wr_en and iss_en and drive rd_data=0, rd_busy=0.
REQ-019 SHALL read entry 0 as zero always; writes and issues to index 0 SHALL be discarded.
REQ-020 SHALL write at rising edge only enabled bytes (wr_be); disabled bytes keep old value (replaces old byte/half merge logic).
REQ-021 SHALL, when both write ports target the same nonzero index in one cycle, apply port 0 then port 1 per byte (port 1 wins on overlapping bytes).
REQ-022 SHALL set busy[iss_addr] at the edge following iss_en; any enabled write to index k SHALL clear busy[k].
REQ-023 SHALL, on simultaneous iss_en and write to the same index, leave busy set (newer producer wins) while still writing data.
REQ-024 SHALL drive rd_busy combinationally from current busy bits (pre-edge values).
REQ-025 SHALL have zero-cycle read latency: rd_data reflects array contents before the current edge unless bypass is enabled (REQ-029).

Reset
REQ-026 SHALL on rf_rst_n low immediately clear all busy bits, init counter, set state INIT, init_done=0, rd_data=0, rd_busy=0.
REQ-027 SHALL restart INIT from index 0 if reset asserts mid-INIT or mid-write; an in-flight write is lost.

Configuration
REQ-028 SHALL compile in write-to-read bypass only under macro PIPE_RF_BYPASS_EN.
REQ-029 SHALL with PIPE_RF_BYPASS_EN, in READY, return for each read port the byte-merged value being written this cycle (REQ-020/021 rules) when rd_addr matches an enabled nonzero wr_addr, and SHALL report rd_busy=0 for that port unless iss_en targets it; without the macro, reads return pre-edge contents and pre-edge busy.

Structure
REQ-030 SHALL place FSM state encoding (INIT, READY) and default width constants in shared package pipe_rf_pkg.
REQ-031 SHALL isolate the busy-bit array with set/clear priority in sub-module pipe_rf_scoreboard.

Verification
REQ-032 SHALL test reset release: init_done rises exactly 32 cycles after rf_rst_n high (ADDR_W=5), all reads 0 before and after.
REQ-033 SHALL test byte write: write 0x11223344 to r5, then wr_be=0b0010 data 0x0000AA00 -> r5 reads 0x1122AA44.
REQ-034 SHALL test dual-port collision: port0 writes 0xFFFFFFFF be=1111, port1 writes 0x00000000 be=0011 to r7 -> r7 reads 0xFFFF0000.
REQ-035 SHALL test scoreboard: iss r9 -> rd_busy=1 next cycle; write r9 -> 0 next cycle; iss+write r9 same cycle -> stays 1; iss r0 -> never busy.
REQ-036 SHALL test bypass (macro on): write 0xDEADBEEF to r3 while reading r3 -> same-cycle rd_data 0xDEADBEEF; macro off -> old value, new value next cycle.
REQ-037 SHALL test mid-INIT reset at cycle 10: init_done stays 0, full 32-cycle INIT repeats, prior contents read 0.

Source files
------------

// File: rtl/pipe_rf_pkg.sv
// Shared types and default sizes for the pipe_rf register file.
package pipe_rf_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 3;
    localparam int DEF_NUM_WR = 2;

endpackage

// File: rtl/pipe_rf_scoreboard.sv
// Busy-bit array: one pending-producer flag per register index.
// A set on the same edge as a clear wins, and index 0 can never be busy.
module pipe_rf_scoreboard
    import pipe_rf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_WR = DEF_NUM_WR
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     set_en_i,
    input  logic [ADDR_W-1:0]        set_addr_i,
    input  logic [NUM_WR-1:0]        clr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] clr_addr_i,
    output logic [2**ADDR_W-1:0]     busy_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (clr_en_i[p]) busy_d[clr_addr_i[p*ADDR_W +: ADDR_W]] = 1'b0;
        end
        if (set_en_i) busy_d[set_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/pipe_rf.sv
// Multi-ported register file with byte-enabled writes, an issue scoreboard and a
// self-clearing INIT sweep. Optional write-to-read bypass under PIPE_RF_BYPASS_EN.
module pipe_rf
    import pipe_rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int NUM_WR = DEF_NUM_WR
) (
    input  logic                       rf_clk,
    input  logic                       rf_rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W/8-1:0] wr_be,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic                       init_done
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic                ready;
    logic [ADDR_W-1:0]   wa [NUM_WR];
    logic [NUM_WR-1:0]   wr_act;
    logic                iss_act;
    logic [DEPTH-1:0]    busy;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == ADDR_W'(DEPTH-1)) state_d = ST_READY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge rf_clk or negedge rf_rst_n) begin
        if (!rf_rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    assign ready     = (state_q == ST_READY);
    assign init_done = ready;
    assign iss_act   = ready && iss_en && (iss_addr != '0);

    // Writes and issues are only honoured in READY and never to index 0.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            wa[p]     = wr_addr[p*ADDR_W +: ADDR_W];
            wr_act[p] = ready && wr_en[p] && (wa[p] != '0);
        end
    end

    // Later ports are applied last, so port 1 wins on overlapping bytes.
    always_ff @(posedge rf_clk) begin
        if (!ready) begin
            mem_q[init_cnt_q] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_act[p] && wr_be[p*NB+b])
                        mem_q[wa[p]][b*8 +: 8] <= wr_data[p*DATA_W + b*8 +: 8];
                end
            end
        end
    end

    pipe_rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk_i      (rf_clk),
        .rst_ni     (rf_rst_n),
        .set_en_i   (iss_act),
        .set_addr_i (iss_addr),
        .clr_en_i   (wr_act),
        .clr_addr_i (wr_addr),
        .busy_o     (busy)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rv;
            logic              rb;
`ifdef PIPE_RF_BYPASS_EN
            logic              hit;
`endif
            ra = rd_addr[i*ADDR_W +: ADDR_W];
            rv = '0;
            rb = 1'b0;
            if (ready && (ra != '0)) begin
                rv = mem_q[ra];
                rb = busy[ra];
`ifdef PIPE_RF_BYPASS_EN
                // Forward the merged in-flight write; busy reflects the post-edge state.
                hit = 1'b0;
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_act[p] && (wa[p] == ra)) begin
                        hit = 1'b1;
                        for (int b = 0; b < NB; b++) begin
                            if (wr_be[p*NB+b]) rv[b*8 +: 8] = wr_data[p*DATA_W + b*8 +: 8];
                        end
                    end
                end
                if (hit) rb = iss_act && (iss_addr == ra);
`endif
            end
            rd_data[i*DATA_W +: DATA_W] = rv;
            rd_busy[i]                  = rb;
        end
    end

endmodule

// File: tb/tb_pipe_rf.sv
// Scoreboard bench for pipe_rf: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_pipe_rf;

    logic        rf_clk = 1'b0;
    logic        rf_rst_n = 1'b0;
    logic [14:0] rd_addr;
    logic [95:0] rd_data;
    logic [2:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_be;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        init_done;

    pipe_rf dut (
        .rf_clk    (rf_clk),
        .rf_rst_n  (rf_rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .init_done (init_done)
    );

    always #5 rf_clk = ~rf_clk;

    localparam int K_DONE = 0, K_DATA = 1, K_BUSY = 2;

    typedef struct {
        int          cyc;
        int          kind;
        int          idx;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge rf_clk) cyc <= cyc + 1;

    exp_t        m_e;
    logic [31:0] m_act;
    always @(negedge rf_clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e = q.pop_front();
            case (m_e.kind)
                K_DONE:  m_act = {31'd0, init_done};
                K_DATA:  m_act = rd_data[m_e.idx*32 +: 32];
                default: m_act = {31'd0, rd_busy[m_e.idx]};
            endcase
            n_tests++;
            if (m_e.cyc != cyc || m_act !== m_e.val) begin
                n_fail++;
                $display("FAIL %s (cycle %0d): got %h, expected %h", m_e.name, m_e.cyc, m_act, m_e.val);
            end
        end
    end

    task automatic expect_now(input int kind, input int idx, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge rf_clk);
        #1;
    endtask

    task automatic idle();
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_be = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    task automatic set_rd(input int i, input logic [4:0] a);
        rd_addr[i*5 +: 5] = a;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*5 +: 5] = a;
        wr_be[p*4 +: 4] = be;
        wr_data[p*32 +: 32] = d;
    endtask

    // Call in the cycle right after reset release: 32 INIT cycles then READY.
    task automatic init_wait(input logic [4:0] a);
        idle();
        set_rd(0, a);
        for (int k = 0; k < 32; k++) begin
            expect_now(K_DONE, 0, 32'd0, "init_done_low");
            expect_now(K_DATA, 0, 32'd0, "init_read_zero");
            tick();
        end
        expect_now(K_DONE, 0, 32'd1, "init_done_rise");
        expect_now(K_DATA, 0, 32'd0, "ready_read_zero");
    endtask

    initial begin
        idle();
        rf_rst_n = 1'b0;
        set_rd(0, 5'd12);
        tick(); tick();
        expect_now(K_DONE, 0, 32'd0, "reset_init_done");
        expect_now(K_DATA, 0, 32'd0, "reset_rd_data");
        expect_now(K_BUSY, 0, 32'd0, "reset_rd_busy");
        tick();
        rf_rst_n = 1'b1;
        init_wait(5'd12);
        tick();

        // Byte-enabled write
        idle(); wr(0, 5'd5, 4'b1111, 32'h11223344);
        tick();
        idle(); wr(0, 5'd5, 4'b0010, 32'h0000AA00); set_rd(1, 5'd5);
`ifdef PIPE_RF_BYPASS_EN
        expect_now(K_DATA, 1, 32'h1122AA44, "byte_wr_same_cycle");
`else
        expect_now(K_DATA, 1, 32'h11223344, "byte_wr_same_cycle");
`endif
        tick();
        idle(); set_rd(0, 5'd5);
        expect_now(K_DATA, 0, 32'h1122AA44, "byte_wr_merge");
        tick();

        // Dual-port collision on r7
        idle(); wr(0, 5'd7, 4'b1111, 32'hFFFFFFFF); wr(1, 5'd7, 4'b0011, 32'h00000000); set_rd(0, 5'd7);
`ifdef PIPE_RF_BYPASS_EN
        expect_now(K_DATA, 0, 32'hFFFF0000, "collide_same_cycle");
`else
        expect_now(K_DATA, 0, 32'h00000000, "collide_same_cycle");
`endif
        tick();
        idle(); set_rd(2, 5'd7);
        expect_now(K_DATA, 2, 32'hFFFF0000, "collide_port1_wins");
        tick();

        // Index 0 discards writes and issues
        idle(); wr(0, 5'd0, 4'b1111, 32'hCAFEBABE); iss_en = 1'b1; iss_addr = 5'd0;
        tick();
        idle(); set_rd(0, 5'd0);
        expect_now(K_DATA, 0, 32'd0, "r0_data_zero");
        expect_now(K_BUSY, 0, 32'd0, "r0_never_busy");
        tick();

        // Scoreboard on r9
        idle(); iss_en = 1'b1; iss_addr = 5'd9; set_rd(2, 5'd9);
        expect_now(K_BUSY, 2, 32'd0, "iss_busy_pre_edge");
        tick();
        idle(); set_rd(2, 5'd9);
        expect_now(K_BUSY, 2, 32'd1, "iss_busy_set");
        tick();
        idle(); wr(1, 5'd9, 4'b1111, 32'h00000099); set_rd(2, 5'd9);
`ifdef PIPE_RF_BYPASS_EN
        expect_now(K_BUSY, 2, 32'd0, "wr_busy_same_cycle");
`else
        expect_now(K_BUSY, 2, 32'd1, "wr_busy_same_cycle");
`endif
        tick();
        idle(); set_rd(2, 5'd9);
        expect_now(K_BUSY, 2, 32'd0, "wr_busy_clear");
        tick();
        idle(); iss_en = 1'b1; iss_addr = 5'd9; wr(0, 5'd9, 4'b1111, 32'h00000012); set_rd(1, 5'd9);
`ifdef PIPE_RF_BYPASS_EN
        expect_now(K_BUSY, 1, 32'd1, "iss_wr_busy_same_cycle");
`else
        expect_now(K_BUSY, 1, 32'd0, "iss_wr_busy_same_cycle");
`endif
        tick();
        idle(); set_rd(1, 5'd9);
        expect_now(K_BUSY, 1, 32'd1, "iss_wr_busy_stays");
        expect_now(K_DATA, 1, 32'h00000012, "iss_wr_data");
        tick();

        // Write-to-read bypass on r3
        idle(); wr(0, 5'd3, 4'b1111, 32'h01020304);
        tick();
        idle(); wr(1, 5'd3, 4'b1111, 32'hDEADBEEF); set_rd(0, 5'd3);
`ifdef PIPE_RF_BYPASS_EN
        expect_now(K_DATA, 0, 32'hDEADBEEF, "bypass_same_cycle");
`else
        expect_now(K_DATA, 0, 32'h01020304, "bypass_same_cycle");
`endif
        tick();
        idle(); set_rd(0, 5'd3);
        expect_now(K_DATA, 0, 32'hDEADBEEF, "bypass_next_cycle");
        tick();

        // Reset with an in-flight write, then a second reset mid-INIT
        idle(); wr(0, 5'd12, 4'b1111, 32'h12345678);
        tick();
        idle(); set_rd(0, 5'd12);
        expect_now(K_DATA, 0, 32'h12345678, "r12_before_reset");
        tick();
        rf_rst_n = 1'b0;
        wr(0, 5'd12, 4'b1111, 32'h00000BAD);
        expect_now(K_DONE, 0, 32'd0, "async_reset_done");
        expect_now(K_DATA, 0, 32'd0, "async_reset_data");
        tick();
        idle(); rf_rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            expect_now(K_DONE, 0, 32'd0, "mid_init_done_low");
            tick();
        end
        rf_rst_n = 1'b0;
        expect_now(K_DONE, 0, 32'd0, "mid_init_reset");
        tick();
        rf_rst_n = 1'b1;
        init_wait(5'd12);
        tick();
        tick();

        if (q.size() != 0) begin
            n_tests += q.size();
            n_fail  += q.size();
            $display("FAIL leftover_expectations: got %0d unchecked, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
